fft16_input_sequencer: RTL
==========================

// Module: fft16_input_sequencer
// PURPOSE
//  Ping-pong input buffer and scheduler feeding the 16-point radix-4 FFT first stage.
//  Accepts one complex sample per valid/ready handshake into one of two 16-entry banks.
//  When a bank is full, it issues four butterfly groups to the stage-1 butterfly.
//  Group q carries x[q], x[q+4], x[q+8], x[q+12] and q = 0..3.
//  Loading of the next frame overlaps draining of the current one.
// PARAMETERS
//  DATA_W  32  sample width in bits: packed complex {re[DATA_W/2], im[DATA_W/2]}, signed
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  reset       in   1        asynchronous, active-high
//  in_valid    in   1        upstream sample valid
//  in_data     in   DATA_W   sample in natural order n = 0..15
//  in_ready    out  1        buffer can accept in_data this cycle
//  out_valid   out  1        group on out_x0..3 is valid
//  out_ready   in   1        butterfly accepts group
//  out_x0      out  DATA_W   x[q]
//  out_x1      out  DATA_W   x[q+4]
//  out_x2      out  DATA_W   x[q+8]
//  out_x3      out  DATA_W   x[q+12]
//  out_q       out  2        group index (twiddle select downstream)
//  out_last    out  1        high with group q=3 (end of frame)
//  frame_done  out  1        1-cycle pulse after the q=3 handshake
// BEHAVIOUR
//  Reset values:
//   - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_idx=0, q=0.
//   - in_ready=1 after reset deasserts. out_valid=0, out_q=0, out_last=0, frame_done=0.
//   - out_x0..3 are don't-care while out_valid=0; bench must not check them.
//  Bank state per bank: EMPTY -> FILLING (first write) -> FULL (write idx 15) -> EMPTY (q=3 handshake).
//  Input path:
//   - in_ready = (state[wr_bank] != FULL), registered.
//   - On in_valid&&in_ready: mem[wr_bank][wr_idx] <= in_data, wr_idx++.
//   - At wr_idx==15: bank becomes FULL, wr_idx wraps to 0, wr_bank toggles.
//   - in_data is ignored when in_valid=0 or in_ready=0; no partial-frame timeout.
//  Output path:
//   - out_valid = (state[rd_bank]==FULL), registered.
//   - out_x*, out_q and out_last are a combinational mux of mem[rd_bank] by q.
//   - On out_valid&&out_ready: q++.
//   - On the q==3 handshake: bank -> EMPTY, q -> 0, rd_bank toggles, frame_done pulses next cycle.
//   - While out_valid=1 && out_ready=0: all outputs are held stable (AXI-style).
//  Latency:
//   - 16th sample accepted at edge N -> out_valid=1 after edge N+1.
//   - Steady state with out_ready=1: 4 output cycles per 16 input cycles.
//  Simultaneous events:
//   - Bank freed (q=3 handshake) and other bank being written in same cycle: both take effect.
//   - Freed bank shows in_ready=1 from the following cycle.
//   - Both banks FULL: in_ready=0 until the first q=3 handshake; no sample is lost or overwritten.
//   - Write completing a bank while the other bank drains: rd_bank switches only on the q=3 handshake.
//  Reset mid-frame: immediate return to reset values. Partial frames and pending groups are discarded.
//  No arithmetic: data passes unmodified; indices wrap modulo 16 (wr_idx) and modulo 4 (q).
// STRUCTURE
//  Shared package fft16_pkg:
//   - FFT_N=16, RADIX=4, GROUPS=4
//   - bank_state_t enum {EMPTY, FILLING, FULL}
//   - sample_t typedef [DATA_W-1:0]
//  Sub-module fft16_bank (one 16xDATA_W register bank):
//   - Write port: we, widx.
//   - Read ports: four taps selected by q, reading idx q, q+4, q+8, q+12.
//   - Instantiated twice.
//  Top contains the bank-state FSMs, pointers, handshake logic and the output bank mux.
// TESTING
//  - Reset, then 16 samples 0..15 with out_ready=1:
//    groups (0,4,8,12,q0), (1,5,9,13,q1), (2,6,10,14,q2), (3,7,11,15,q3,last); one frame_done pulse.
//  - Continuous 64 samples, in_valid=1, out_ready=1:
//    in_ready never drops; 16 groups out in frame order; values match x[q+4k] per frame.
//  - out_ready=0 forever while streaming 40 samples:
//    in_ready drops after sample 31; samples 32+ stall.
//    Outputs hold group (0,4,8,12) stable; raising out_ready drains frame 0 then frame 1 intact.
//  - Random in_valid/out_ready bubbles (50%), 10 frames:
//    scoreboard match, no loss or duplication; out_* stable while valid&&!ready.
//  - Assert reset after sample 9 of frame 1, while frame 0 is at q=2:
//    out_valid=0 and in_ready=1 next cycle; new frame of 16 samples produces correct groups from q=0.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point radix-4 FFT front end.
// Imported by the input sequencer and its register banks.
package fft16_pkg;

  localparam int FFT_N    = 16;
  localparam int RADIX    = 4;
  localparam int GROUPS   = 4;
  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fft16_bank.sv
// One 16-entry sample bank with a single write port and four
// stride-4 read taps (x[q], x[q+4], x[q+8], x[q+12]).
module fft16_bank
  import fft16_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        q,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2,
  output logic [DATA_W-1:0] tap3
);

  logic [DATA_W-1:0] mem [FFT_N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // index q + 4k is simply {k, q}
  assign tap0 = mem[{2'd0, q}];
  assign tap1 = mem[{2'd1, q}];
  assign tap2 = mem[{2'd2, q}];
  assign tap3 = mem[{2'd3, q}];

endmodule

// File: rtl/fft16_input_sequencer.sv
// Ping-pong input buffer that reorders 16 natural-order samples into
// four radix-4 butterfly groups for the first FFT stage.
module fft16_input_sequencer
  import fft16_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x0,
  output logic [DATA_W-1:0] out_x1,
  output logic [DATA_W-1:0] out_x2,
  output logic [DATA_W-1:0] out_x3,
  output logic [1:0]        out_q,
  output logic              out_last,
  output logic              frame_done
);

  bank_state_t st   [2];
  bank_state_t st_n [2];

  logic       wr_bank, wr_bank_n;
  logic       rd_bank, rd_bank_n;
  logic [3:0] wr_idx, wr_idx_n;
  logic [1:0] q, q_n;
  logic       in_ready_n, out_valid_n;
  logic       wr_fire, rd_fire, rd_last;

  logic [DATA_W-1:0] t0 [GROUPS];
  logic [DATA_W-1:0] t1 [GROUPS];

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign rd_last = rd_fire & (q == 2'd3);

  always_comb begin
    st_n      = st;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank;
    wr_idx_n  = wr_idx;
    q_n       = q;
    if (wr_fire) begin
      wr_idx_n = wr_idx + 4'd1;
      if (wr_idx == 4'd15) begin
        st_n[wr_bank] = FULL;
        wr_bank_n     = ~wr_bank;
      end else begin
        st_n[wr_bank] = FILLING;
      end
    end
    // never collides with the write above: a FULL bank takes no writes
    if (rd_fire) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        st_n[rd_bank] = EMPTY;
        rd_bank_n     = ~rd_bank;
      end
    end
    in_ready_n  = (st_n[wr_bank_n] != FULL);
    // one-cycle gap after a frame so out_valid never shows a freed bank
    out_valid_n = !rd_last && (st[rd_bank] == FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_idx     <= 4'd0;
      q          <= 2'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      st         <= st_n;
      wr_bank    <= wr_bank_n;
      rd_bank    <= rd_bank_n;
      wr_idx     <= wr_idx_n;
      q          <= q_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      frame_done <= rd_last;
    end
  end

  fft16_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_fire & ~wr_bank),
    .widx  (wr_idx),
    .wdata (in_data),
    .q     (q),
    .tap0  (t0[0]),
    .tap1  (t0[1]),
    .tap2  (t0[2]),
    .tap3  (t0[3])
  );

  fft16_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_fire & wr_bank),
    .widx  (wr_idx),
    .wdata (in_data),
    .q     (q),
    .tap0  (t1[0]),
    .tap1  (t1[1]),
    .tap2  (t1[2]),
    .tap3  (t1[3])
  );

  assign out_x0   = rd_bank ? t1[0] : t0[0];
  assign out_x1   = rd_bank ? t1[1] : t0[1];
  assign out_x2   = rd_bank ? t1[2] : t0[2];
  assign out_x3   = rd_bank ? t1[3] : t0[3];
  assign out_q    = q;
  assign out_last = out_valid & (q == 2'd3);

endmodule
